// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op codes, FSM state encodings, iteration count and operand-magnitude helper.
// Pure declarations; no logic, no timing.
package muldiv_unit_pkg;

    // Operation select carried on op[1:0]; op[1] = divide, op[0] = unsigned
    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    // Counter value seen during the final (32nd) iteration
    localparam logic [5:0] MD_LAST_ITER = 6'd31;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_t;

    // Magnitude of a two's-complement value when is_signed, raw value otherwise.
    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes.
// Latency: busy for 33 cycles after start, done pulses the cycle HI/LO update.
// Backpressure: start and MTHI/MTLO are ignored while busy; control unit stalls on busy.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic [31:0] wd,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_t   state;
    md_state_t   next_state;
    logic        busy_nxt;
    logic        done_nxt;

    logic        accept;
    logic [5:0]  cnt;
    logic [63:0] acc;          // {remainder|product-hi, quotient|product-lo}
    logic [31:0] opb;          // multiplicand or divisor magnitude
    logic [1:0]  op_r;
    logic        sign_a;
    logic        sign_b;
    logic        divzero;

    logic        is_div;
    logic        is_signed;
    logic        in_signed;

    logic [32:0] add_x;
    logic [32:0] add_y;
    logic [33:0] sum;
    logic [63:0] acc_step;

    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign accept    = (state == MD_IDLE) && start;
    assign is_div    = op_r[1];
    assign is_signed = ~op_r[0];
    assign in_signed = ~op[0];

    // State register
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= MD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic plus the next values of the registered status outputs
    always_comb begin
        next_state = state;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    next_state = MD_RUN;
                end
            end
            MD_RUN: begin
                if (cnt == MD_LAST_ITER) begin
                    next_state = MD_FIX;
                end
            end
            MD_FIX: begin
                next_state = MD_IDLE;
                done_nxt   = 1'b1;
            end
            default: begin
                next_state = MD_IDLE;
            end
        endcase
        busy_nxt = (next_state != MD_IDLE);
    end

    // busy/done are registered so the control unit sees no input-to-output path
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // One shared 33-bit adder: multiply adds the multiplicand to the upper half,
    // divide subtracts the divisor from the shifted partial remainder (x + ~d + 1).
    // For divide, sum[33] is the carry-out, i.e. "remainder >= divisor".
    always_comb begin
        add_x    = is_div ? acc[63:31] : {1'b0, acc[63:32]};
        add_y    = is_div ? ~{1'b0, opb} : {1'b0, opb};
        sum      = {1'b0, add_x} + {1'b0, add_y} + {33'd0, is_div};
        acc_step = acc;
        if (is_div) begin
            if (sum[33]) begin
                acc_step = {sum[31:0], acc[30:0], 1'b1};
            end else begin
                acc_step = {acc[62:0], 1'b0};
            end
        end else begin
            if (acc[0]) begin
                acc_step = {sum[32:0], acc[31:1]};
            end else begin
                acc_step = {1'b0, acc[63:32], acc[31:1]};
            end
        end
    end

    // Sign correction of the magnitude result; remainder follows the dividend
    always_comb begin
        prod_fix = (is_signed && (sign_a ^ sign_b)) ? (~acc + 64'd1) : acc;
        quo_fix  = (is_signed && (sign_a ^ sign_b)) ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = (is_signed && sign_a) ? (~acc[63:32] + 32'd1) : acc[63:32];
        res_hi   = is_div ? rem_fix : prod_fix[63:32];
        res_lo   = is_div ? quo_fix : prod_fix[31:0];
    end

    // Operand latch on accept, then one shift-add / restoring step per RUN cycle
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            acc     <= 64'd0;
            opb     <= 32'd0;
            op_r    <= MD_MULT;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            divzero <= 1'b0;
            cnt     <= 6'd0;
        end else if (accept) begin
            acc     <= {32'd0, mag32(a, in_signed)};
            opb     <= mag32(b, in_signed);
            op_r    <= op;
            sign_a  <= a[31];
            sign_b  <= b[31];
            divzero <= op[1] && (b == 32'd0);
            cnt     <= 6'd0;
        end else if (state == MD_RUN) begin
            acc     <= acc_step;
            cnt     <= cnt + 6'd1;
        end
    end

    // HI/LO: operation result in FIX (kept on divide-by-zero), MTHI/MTLO only
    // when idle and not starting, so partial results never reach the outputs
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state == MD_FIX) begin
            if (!(is_div && divzero)) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if ((state == MD_IDLE) && !start) begin
            if (wr_hi) begin
                hi <= wd;
            end
            if (wr_lo) begin
                lo <= wd;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed table, corner sequences, random ops.
// Reference model uses plain 64-bit arithmetic on the architectural semantics.
// Inputs driven and outputs sampled on the falling edge.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wd;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wd    (wd),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int launch_cyc = 0;
    int last_done_cyc = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: signed/unsigned 64-bit arithmetic, C-style division
    function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                   inout logic [31:0] h, inout logic [31:0] l);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            MD_MULT: begin
                p = sx * sy;
                h = p[63:32];
                l = p[31:0];
            end
            MD_MULTU: begin
                u = {32'd0, x} * {32'd0, y};
                h = u[63:32];
                l = u[31:0];
            end
            MD_DIV: begin
                if (y != 32'd0) begin
                    q = sx / sy;
                    r = sx % sy;
                    h = r[31:0];
                    l = q[31:0];
                end
            end
            default: begin
                if (y != 32'd0) begin
                    h = x % y;
                    l = x / y;
                end
            end
        endcase
    endfunction

    // Called at a falling edge; presents start for one edge
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic wlo, input logic [31:0] wdat);
        op = o; a = x; b = y; wr_lo = wlo; wd = wdat; start = 1'b1;
        launch_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        wr_lo = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    // Waits (bounded) for done; optionally pokes start+wr_hi mid-operation
    task automatic wait_done(input string name, input int poke_at);
        int n_busy = 0;
        int k = 0;
        while (!done && k < 200) begin
            if (busy) n_busy++;
            if (k == poke_at) begin
                start = 1'b1; wr_hi = 1'b1; wd = 32'h1234_5678;
                op = ~op; a = $urandom; b = $urandom;
            end else begin
                start = 1'b0; wr_hi = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        wr_hi = 1'b0;
        chk({name, "_done"}, done, 1);
        chk({name, "_busy_cycles"}, n_busy, 33);
        chk({name, "_latency"}, cyc - launch_cyc, 34);
        chk({name, "_busy_low_at_done"}, busy, 0);
        last_done_cyc = cyc;
    endtask

    task automatic mt(input logic h, input logic l, input logic [31:0] v);
        wr_hi = h; wr_lo = l; wd = v;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (h) m_hi = v;
        if (l) m_lo = v;
        chk("mt_hi", hi, m_hi);
        chk("mt_lo", lo, m_lo);
    endtask

    task automatic run_model(input string name, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        ref_op(o, x, y, m_hi, m_lo);
        launch(o, x, y, 1'b0, 32'd0);
        wait_done(name, -1);
        chk({name, "_hi"}, hi, m_hi);
        chk({name, "_lo"}, lo, m_lo);
    endtask

    initial begin
        int prev;
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;

        tbl[0] = '{MD_MULT,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        tbl[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE};
        tbl[2] = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        tbl[3] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[4] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        tbl[5] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[6] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        tbl[7] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[8] = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
        tbl[9] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};

        clrn = 1'b0; start = 1'b0; op = MD_MULT; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        clrn = 1'b1;
        @(negedge clk);

        // MTHI/MTLO, both together, then divide-by-zero keeps them
        mt(1'b1, 1'b1, 32'h0F0F_0F0F);
        mt(1'b1, 1'b0, 32'h0000_AAAA);
        mt(1'b0, 1'b1, 32'h0000_5555);
        launch(MD_DIVU, 32'd5, 32'd0, 1'b0, 32'd0);
        wait_done("divzero", -1);
        chk("divzero_hi", hi, 32'h0000_AAAA);
        chk("divzero_lo", lo, 32'h0000_5555);

        // Directed table; each op starts in the previous op's done cycle
        for (int i = 0; i < 10; i++) begin
            launch(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 32'd0);
            wait_done($sformatf("tbl%0d", i), -1);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
            m_hi = tbl[i].hi;
            m_lo = tbl[i].lo;
        end

        // Back-to-back spacing and single-cycle done
        prev = last_done_cyc;
        run_model("b2b", MD_MULTU, 32'd7, 32'd6);
        chk("b2b_spacing", last_done_cyc - prev, 34);
        @(negedge clk);
        chk("done_one_cycle", done, 0);

        // start + MTHI mid-operation are ignored
        run_model("pre_poke", MD_MULT, 32'd2, 32'd3);
        ref_op(MD_DIVU, 32'd1000, 32'd33, m_hi, m_lo);
        launch(MD_DIVU, 32'd1000, 32'd33, 1'b0, 32'd0);
        wait_done("poke", 5);
        chk("poke_hi", hi, m_hi);
        chk("poke_lo", lo, m_lo);

        // start wins over MTLO in the same idle cycle
        ref_op(MD_MULT, 32'd5, 32'd6, m_hi, m_lo);
        launch(MD_MULT, 32'd5, 32'd6, 1'b1, 32'hDEAD_BEEF);
        wait_done("start_wr", -1);
        chk("start_wr_hi", hi, m_hi);
        chk("start_wr_lo", lo, m_lo);

        // Asynchronous reset mid-operation
        launch(MD_MULT, 32'd123456, 32'd789, 1'b0, 32'd0);
        repeat (14) @(negedge clk);
        clrn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        launch(MD_MULT, 32'd3, 32'd4, 1'b0, 32'd0);
        wait_done("after_rst", -1);
        chk("after_rst_hi", hi, 32'd0);
        chk("after_rst_lo", lo, 32'd12);

        // Randomised ops against the reference model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = $urandom_range(1, 15);
                2:       ry = 32'hFFFF_FFFF;
                default: ry = $urandom;
            endcase
            run_model($sformatf("rnd%0d", i), ro, rx, ry);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
